// File: rtl/ocupacion_display_pkg.sv
// Shared constants for the occupancy display: symbol codes,
// active-low gfedcba segment patterns and digit-select values.
package ocupacion_display_pkg;

  typedef enum logic [4:0] {
    SYM_0     = 5'd0,
    SYM_1     = 5'd1,
    SYM_2     = 5'd2,
    SYM_3     = 5'd3,
    SYM_4     = 5'd4,
    SYM_5     = 5'd5,
    SYM_6     = 5'd6,
    SYM_7     = 5'd7,
    SYM_8     = 5'd8,
    SYM_9     = 5'd9,
    SYM_E     = 5'd10,
    SYM_R     = 5'd11,
    SYM_F     = 5'd12,
    SYM_DASH  = 5'd13,
    SYM_BLANK = 5'd14
  } sym_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_0 = 2'd0;
  localparam logic [1:0] DIG_1 = 2'd1;
  localparam logic [1:0] DIG_2 = 2'd2;
  localparam logic [1:0] DIG_3 = 2'd3;

endpackage

// File: rtl/ocupacion_display_seg7_decoder.sv
// Symbol code to active-low gfedcba segments (combinational).
// Ports: code (5-bit symbol), seg (7-bit segments, active-low).
module seg7_decoder
  import ocupacion_display_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      SYM_0:    seg = SEG_0;
      SYM_1:    seg = SEG_1;
      SYM_2:    seg = SEG_2;
      SYM_3:    seg = SEG_3;
      SYM_4:    seg = SEG_4;
      SYM_5:    seg = SEG_5;
      SYM_6:    seg = SEG_6;
      SYM_7:    seg = SEG_7;
      SYM_8:    seg = SEG_8;
      SYM_9:    seg = SEG_9;
      SYM_E:    seg = SEG_E;
      SYM_R:    seg = SEG_R;
      SYM_F:    seg = SEG_F;
      SYM_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ocupacion_display.sv
// 4-digit multiplexed occupancy display with full flag and blinking Err-.
// Ports: clk, reset, conteo, hubo_error, clear_error -> an, sseg, full, error_latched.
module ocupacion_display
  import ocupacion_display_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 25,
  parameter int CAPACITY     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] conteo,
  input  logic       hubo_error,
  input  logic       clear_error,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       full,
  output logic       error_latched
);

  localparam logic [3:0] CAP = 4'(CAPACITY);

  logic [REFRESH_BITS-1:0] refresh;
  logic [BLINK_BITS-1:0]   blink;
  logic [3:0]              conteo_q;
  logic [1:0]              sel;
  logic                    tens;
  logic [3:0]              units;
  logic [4:0]              sym;
  logic [6:0]              seg;
  logic                    blank_phase;
  logic [3:0]              an_next;

  assign sel   = refresh[REFRESH_BITS-1 -: 2];
  assign tens  = (conteo_q >= 4'd10);
  assign units = tens ? conteo_q - 4'd10 : conteo_q;

  // Error display blinks by gating the anodes off.
  assign blank_phase = error_latched & ~blink[BLINK_BITS-1];

  always_comb begin
    sym = SYM_BLANK;
    if (error_latched) begin
      unique case (1'b1)
        sel == DIG_3: sym = SYM_E;
        sel == DIG_2: sym = SYM_R;
        sel == DIG_1: sym = SYM_R;
        sel == DIG_0: sym = SYM_DASH;
        default:      sym = SYM_BLANK;
      endcase
    end else begin
      unique case (1'b1)
        sel == DIG_3: sym = full ? SYM_F : SYM_BLANK;
        sel == DIG_2: sym = SYM_BLANK;
        sel == DIG_1: sym = tens ? SYM_1 : SYM_BLANK;
        sel == DIG_0: sym = {1'b0, units};
        default:      sym = SYM_BLANK;
      endcase
    end
  end

  seg7_decoder u_dec (
    .code (sym),
    .seg  (seg)
  );

  always_comb begin
    an_next = ~(4'b0001 << sel);
    if (blank_phase) an_next = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh       <= '0;
      blink         <= '0;
      conteo_q      <= 4'd0;
      full          <= 1'b0;
      error_latched <= 1'b0;
      an            <= 4'b1111;
      sseg          <= 8'hFF;
    end else begin
      refresh  <= refresh + 1'b1;
      blink    <= blink + 1'b1;
      conteo_q <= conteo;
      full     <= (conteo >= CAP);
      if (hubo_error)
        error_latched <= 1'b1;
      else if (clear_error)
        error_latched <= 1'b0;
      an   <= an_next;
      sseg <= {1'b1, seg};
    end
  end

endmodule

// File: tb/tb_ocupacion_display.sv
// Self-checking bench for ocupacion_display (small counters).
// Vector table, hand sequences and random stimulus against a model.
module tb_ocupacion_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] conteo;
  logic       hubo_error;
  logic       clear_error;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       full;
  logic       error_latched;

  int n_pass = 0;
  int n_total = 0;

  ocupacion_display #(
    .REFRESH_BITS (4),
    .BLINK_BITS   (5),
    .CAPACITY     (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .conteo        (conteo),
    .hubo_error    (hubo_error),
    .clear_error   (clear_error),
    .an            (an),
    .sseg          (sseg),
    .full          (full),
    .error_latched (error_latched)
  );

  always #5 clk = ~clk;

  // model state: cycles since reset, last registered inputs
  int m_cyc;
  int m_cq;
  bit m_full;
  bit m_err;

  logic [3:0] e_an;
  logic [7:0] e_sseg;
  logic       e_full;
  logic       e_err;

  // symbols: 0-9 digits, 10 E, 11 r, 12 F, 13 dash, 14 blank
  function automatic logic [6:0] seg_of(int k);
    case (k)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0000110;
      11: return 7'b0101111;
      12: return 7'b0001110;
      13: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    int d;
    int syms[4];
    if (reset) begin
      e_an = 4'hF;
      e_sseg = 8'hFF;
      e_full = 1'b0;
      e_err = 1'b0;
      m_cyc = 0;
      m_cq = 0;
      m_full = 0;
      m_err = 0;
    end else begin
      d = (m_cyc % 16) / 4;
      if (m_err) begin
        syms[3] = 10; syms[2] = 11; syms[1] = 11; syms[0] = 13;
      end else begin
        syms[3] = m_full ? 12 : 14;
        syms[2] = 14;
        syms[1] = (m_cq / 10 != 0) ? m_cq / 10 : 14;
        syms[0] = m_cq % 10;
      end
      e_sseg = {1'b1, seg_of(syms[d])};
      e_an = (m_err && (m_cyc % 32) < 16) ? 4'hF : ~(4'b0001 << d);
      e_full = (conteo >= 15);
      e_err = hubo_error ? 1'b1 : (clear_error ? 1'b0 : m_err);
      m_full = e_full;
      m_err = e_err;
      m_cq = int'(conteo);
      m_cyc++;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("sseg", 32'(sseg), 32'(e_sseg));
    chk("full", 32'(full), 32'(e_full));
    chk("error_latched", 32'(error_latched), 32'(e_err));
  endtask

  typedef struct {
    logic [3:0] conteo;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d3;
    logic       full;
  } vec_t;

  vec_t vecs[7];

  logic [7:0] cap[4];
  int blanks;

  task automatic run_capture(int n);
    for (int k = 0; k < 4; k++) cap[k] = 8'h00;
    blanks = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      case (an)
        4'b1110: cap[0] = sseg;
        4'b1101: cap[1] = sseg;
        4'b1011: cap[2] = sseg;
        4'b0111: cap[3] = sseg;
        4'b1111: blanks++;
        default: ;
      endcase
    end
  endtask

  initial begin
    vecs[0] = '{4'd0,  8'hC0, 8'hFF, 8'hFF, 1'b0};
    vecs[1] = '{4'd7,  8'hF8, 8'hFF, 8'hFF, 1'b0};
    vecs[2] = '{4'd12, 8'hA4, 8'hF9, 8'hFF, 1'b0};
    vecs[3] = '{4'd15, 8'h92, 8'hF9, 8'h8E, 1'b1};
    vecs[4] = '{4'd9,  8'h90, 8'hFF, 8'hFF, 1'b0};
    vecs[5] = '{4'd10, 8'hC0, 8'hF9, 8'hFF, 1'b0};
    vecs[6] = '{4'd14, 8'h99, 8'hF9, 8'hFF, 1'b0};

    reset = 1'b1;
    conteo = 4'd0;
    hubo_error = 1'b0;
    clear_error = 1'b0;
    tick();
    tick();
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_sseg", 32'(sseg), 32'hFF);
    reset = 1'b0;

    // first digit after reset is digit 0 for four cycles
    tick();
    chk("first_an", 32'(an), 32'hE);
    chk("first_sseg", 32'(sseg), 32'hC0);

    foreach (vecs[i]) begin
      conteo = vecs[i].conteo;
      run_capture(20);
      chk($sformatf("vec%0d_d0", i), 32'(cap[0]), 32'(vecs[i].d0));
      chk($sformatf("vec%0d_d1", i), 32'(cap[1]), 32'(vecs[i].d1));
      chk($sformatf("vec%0d_d2", i), 32'(cap[2]), 32'hFF);
      chk($sformatf("vec%0d_d3", i), 32'(cap[3]), 32'(vecs[i].d3));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
    end

    // one-cycle error pulse latches and blinks
    conteo = 4'd3;
    hubo_error = 1'b1;
    tick();
    hubo_error = 1'b0;
    chk("err_set", 32'(error_latched), 32'h1);
    run_capture(40);
    chk("err_hold", 32'(error_latched), 32'h1);
    chk("err_d3", 32'(cap[3]), 32'h86);
    chk("err_d2", 32'(cap[2]), 32'hAF);
    chk("err_d1", 32'(cap[1]), 32'hAF);
    chk("err_d0", 32'(cap[0]), 32'hBF);
    chk("err_blank_seen", 32'(blanks > 0), 32'h1);

    // set wins over clear; clear alone releases
    hubo_error = 1'b1;
    clear_error = 1'b1;
    tick();
    chk("set_wins", 32'(error_latched), 32'h1);
    hubo_error = 1'b0;
    tick();
    chk("clear", 32'(error_latched), 32'h0);
    clear_error = 1'b0;
    run_capture(20);
    chk("resume_d0", 32'(cap[0]), 32'hB0);
    chk("resume_blank", 32'(blanks), 32'h0);

    // reset mid-display in error mode with a full lot
    conteo = 4'd15;
    hubo_error = 1'b1;
    tick();
    hubo_error = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    reset = 1'b1;
    tick();
    chk("mid_reset_an", 32'(an), 32'hF);
    chk("mid_reset_sseg", 32'(sseg), 32'hFF);
    chk("mid_reset_full", 32'(full), 32'h0);
    chk("mid_reset_err", 32'(error_latched), 32'h0);
    reset = 1'b0;
    tick();
    chk("post_reset_an", 32'(an), 32'hE);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      conteo = 4'($urandom_range(0, 15));
      hubo_error = ($urandom_range(0, 39) == 0);
      clear_error = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
